// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg                                                              |
// | Opcodes, FSM state type and opcode classification shared by the      |
// | sequential ALU and its iterative multiply/divide engine.             |
// | Build option: ALU_FAST_MUL_EN (multiply becomes single-cycle).       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

   // Legacy 3-bit ALUctr codes live at ALUctr[3]=0; extensions at ALUctr[3]=1
   localparam logic [3:0] OP_ADDU  = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_OR    = 4'b0010;
   localparam logic [3:0] OP_RSV0  = 4'b0011;
   localparam logic [3:0] OP_SUBU  = 4'b0100;
   localparam logic [3:0] OP_SUB   = 4'b0101;
   localparam logic [3:0] OP_SLTU  = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_AND   = 4'b1000;
   localparam logic [3:0] OP_XOR   = 4'b1001;
   localparam logic [3:0] OP_NOR   = 4'b1010;
   localparam logic [3:0] OP_RSV1  = 4'b1011;
   localparam logic [3:0] OP_MULTU = 4'b1100;
   localparam logic [3:0] OP_MULT  = 4'b1101;
   localparam logic [3:0] OP_DIVU  = 4'b1110;
   localparam logic [3:0] OP_DIV   = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } alu_state_e;

   // True when the opcode goes through the iterative engine
   function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_FAST_MUL_EN
      return (op[3:1] == 3'b111);
`else
      return (op[3:2] == 2'b11);
`endif
   endfunction

   // Divide opcodes (DIVU/DIV); op[0] selects the signed variant
   function automatic logic is_div_op(input logic [3:0] op);
      return (op[3:1] == 3'b111);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_muldiv_iter                                                      |
// | Radix-2 iterative engine: shift-add multiply and restoring divide on |
// | operand magnitudes, with sign correction of the final step.          |
// | load: latch operands; step: one iteration; fin: last iteration,      |
// | res_lo/res_hi then carry the corrected result and state is cleared.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int N  = 32,
   parameter int CW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          step,
   input  logic          fin,
   input  logic          op_div,
   input  logic          op_signed,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   output logic          last,
   output logic [N-1:0]  res_lo,
   output logic [N-1:0]  res_hi
);

   // hi: partial product / remainder; lo: multiplier / quotient;
   // opnd: multiplicand / divisor
   logic [N-1:0]   hi_q, hi_d;
   logic [N-1:0]   lo_q, lo_d;
   logic [N-1:0]   opnd_q, opnd_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           div_q, div_d;
   logic           neg_a_q, neg_a_d;
   logic           neg_b_q, neg_b_d;
   logic           bzero_q, bzero_d;

   logic           in_neg_a, in_neg_b;
   logic [N-1:0]   mag_a, mag_b;
   logic [N:0]     mul_sum;
   logic [N-1:0]   div_trial;
   logic           div_take;
   logic [N-1:0]   step_hi, step_lo;
   logic [2*N-1:0] prod_fix;

   // Convert incoming operands to magnitudes; the most-negative value maps to 2^(N-1)
   always_comb begin
      in_neg_a = op_signed & a[N-1];
      in_neg_b = op_signed & b[N-1];
      mag_a    = in_neg_a ? -a : a;
      mag_b    = in_neg_b ? -b : b;
   end

   // One iteration; the divide drops the trial's top bit because hi[N-1] already forces a subtract
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_trial = {hi_q[N-2:0], lo_q[N-1]};
      div_take  = hi_q[N-1] | (div_trial >= opnd_q);
      if (div_q) begin
         step_hi = div_take ? (div_trial - opnd_q) : div_trial;
         step_lo = {lo_q[N-2:0], div_take};
      end else begin
         step_hi = mul_sum[N:1];
         step_lo = {mul_sum[0], lo_q[N-1:1]};
      end
   end

   // Sign correction applied to the value produced by this cycle's step
   always_comb begin
      prod_fix = {step_hi, step_lo};
      if (neg_a_q ^ neg_b_q) begin
         prod_fix = -{step_hi, step_lo};
      end
      if (div_q) begin
         // Divide by zero leaves the dividend magnitude in hi, so the remainder path restores A
         res_lo = bzero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -step_lo : step_lo);
         res_hi = neg_a_q ? -step_hi : step_hi;
      end else begin
         res_lo = prod_fix[N-1:0];
         res_hi = prod_fix[2*N-1:N];
      end
   end

   // Engine register updates: load has priority, fin clears, step iterates
   always_comb begin
      hi_d    = hi_q;
      lo_d    = lo_q;
      opnd_d  = opnd_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      bzero_d = bzero_q;
      if (load) begin
         div_d   = op_div;
         neg_a_d = in_neg_a;
         neg_b_d = in_neg_b;
         bzero_d = (b == '0);
         hi_d    = '0;
         lo_d    = op_div ? mag_a : mag_b;
         opnd_d  = op_div ? mag_b : mag_a;
         cnt_d   = CW'(N);
      end else if (fin) begin
         hi_d    = '0;
         lo_d    = '0;
         opnd_d  = '0;
         cnt_d   = '0;
      end else if (step) begin
         hi_d    = step_hi;
         lo_d    = step_lo;
         cnt_d   = cnt_q - CW'(1);
      end
   end

   assign last = (cnt_q == CW'(1));

   // Engine state flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q    <= '0;
         lo_q    <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         bzero_q <= 1'b0;
      end else begin
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         bzero_q <= bzero_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq                                                              |
// | Registered ALU with start/busy/done handshake. Single-cycle ops are  |
// | computed here; MUL/DIV run in alu_muldiv_iter under the IDLE/CALC/   |
// | FIX state machine. FIX is the done cycle and accepts a new start.    |
// | Build option: ALU_FAST_MUL_EN (combinational N x N multiply).        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_seq
   import alu_pkg::*;
#(
   parameter int N  = 32,
   parameter int CW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [3:0]    ALUctr,
   input  logic [N-1:0]  A,
   input  logic [N-1:0]  B,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  Result,
   output logic [N-1:0]  ResultHi,
   output logic          Zero,
   output logic          Overflow
);

   alu_state_e    state_q, state_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;
   logic          zero_q, zero_d;
   logic [N-1:0]  result_q, result_d;
   logic [N-1:0]  result_hi_q, result_hi_d;

   logic          md_load, md_step, md_fin, md_last;
   logic [N-1:0]  md_lo, md_hi;

   logic [N-1:0]  add_res;
   logic [N:0]    sub_full;
   logic          add_ovf, sub_ovf;
   logic [N-1:0]  sc_lo, sc_hi;
   logic          sc_ovf;

`ifdef ALU_FAST_MUL_EN
   logic [2*N-1:0] fast_prod;
   logic           fast_sx;

   // Sign-extend to 2N bits so one unsigned multiplier serves MULT and MULTU
   always_comb begin
      fast_sx   = ALUctr[0];
      fast_prod = {{N{fast_sx & A[N-1]}}, A} * {{N{fast_sx & B[N-1]}}, B};
   end
`endif

   // Single-cycle result; sub_full[N] is the unsigned borrow used by SLTU
   always_comb begin
      add_res  = A + B;
      sub_full = {1'b0, A} - {1'b0, B};
      add_ovf  = (A[N-1] == B[N-1]) && (add_res[N-1] != A[N-1]);
      sub_ovf  = (A[N-1] != B[N-1]) && (sub_full[N-1] != A[N-1]);
      sc_lo    = '0;
      sc_hi    = '0;
      sc_ovf   = 1'b0;
      case (ALUctr)
         OP_ADDU: sc_lo = add_res;
         OP_ADD: begin
            sc_lo  = add_res;
            sc_ovf = add_ovf;
         end
         OP_OR:   sc_lo = A | B;
         OP_SUBU: sc_lo = sub_full[N-1:0];
         OP_SUB: begin
            sc_lo  = sub_full[N-1:0];
            sc_ovf = sub_ovf;
         end
         OP_SLTU: sc_lo = {{(N-1){1'b0}}, sub_full[N]};
         OP_SLT:  sc_lo = {{(N-1){1'b0}}, sub_full[N-1] ^ sub_ovf};
         OP_AND:  sc_lo = A & B;
         OP_XOR:  sc_lo = A ^ B;
         OP_NOR:  sc_lo = ~(A | B);
`ifdef ALU_FAST_MUL_EN
         OP_MULTU, OP_MULT: begin
            sc_lo = fast_prod[N-1:0];
            sc_hi = fast_prod[2*N-1:N];
         end
`endif
         default: ;
      endcase
   end

   // Control FSM: accept work in IDLE/FIX, iterate in CALC, capture on the final step
   always_comb begin
      state_d     = state_q;
      done_d      = 1'b0;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      md_load     = 1'b0;
      md_step     = 1'b0;
      md_fin      = 1'b0;
      case (state_q)
         ST_IDLE, ST_FIX: begin
            state_d = ST_IDLE;
            if (start) begin
               if (is_multicycle(ALUctr)) begin
                  md_load = 1'b1;
                  state_d = ST_CALC;
               end else begin
                  result_d    = sc_lo;
                  result_hi_d = sc_hi;
                  zero_d      = (sc_lo == '0);
                  ovf_d       = sc_ovf;
                  done_d      = 1'b1;
               end
            end
         end
         ST_CALC: begin
            md_step = 1'b1;
            if (md_last) begin
               md_fin      = 1'b1;
               result_d    = md_lo;
               result_hi_d = md_hi;
               zero_d      = (md_lo == '0);
               ovf_d       = 1'b0;
               done_d      = 1'b1;
               state_d     = ST_FIX;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Architectural state; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         done_q      <= 1'b0;
         result_q    <= '0;
         result_hi_q <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
      end
   end

   alu_muldiv_iter #(
      .N  (N),
      .CW (CW)
   ) u_muldiv (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (md_load),
      .step      (md_step),
      .fin       (md_fin),
      .op_div    (is_div_op(ALUctr)),
      .op_signed (ALUctr[0]),
      .a         (A),
      .b         (B),
      .last      (md_last),
      .res_lo    (md_lo),
      .res_hi    (md_hi)
   );

   assign busy     = (state_q == ST_CALC);
   assign done     = done_q;
   assign Result   = result_q;
   assign ResultHi = result_hi_q;
   assign Zero     = zero_q;
   assign Overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_seq                                                           |
// | Scoreboard bench: the driver pushes model results with the expected  |
// | done cycle; a negedge monitor pops and compares on every done pulse. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_seq;
   import alu_pkg::*;

   localparam int N  = 32;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [3:0]    ALUctr;
   logic [N-1:0]  A, B;
   logic          busy, done, Zero, Overflow;
   logic [N-1:0]  Result, ResultHi;

   typedef struct packed {
      logic [N-1:0] lo;
      logic [N-1:0] hi;
      logic         zero;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   alu_seq #(.N(N), .CW(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .ALUctr   (ALUctr),
      .A        (A),
      .B        (B),
      .busy     (busy),
      .done     (done),
      .Result   (Result),
      .ResultHi (ResultHi),
      .Zero     (Zero),
      .Overflow (Overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
      end
   endtask

   // Reference behaviour from plain integer arithmetic
   function automatic exp_t model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      longint sa, sb, s, smax, smin;
      longint unsigned ua, ub;
      logic [63:0] p;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      ua   = 64'(a);
      ub   = 64'(b);
      smax = (longint'(1) <<< (N-1)) - 1;
      smin = -(longint'(1) <<< (N-1));
      e.lo = '0; e.hi = '0; e.ovf = 1'b0; e.cyc = 0;
      case (op)
         4'b0000: e.lo = a + b;
         4'b0001: begin e.lo = a + b; s = sa + sb; e.ovf = (s > smax) || (s < smin); end
         4'b0010: e.lo = a | b;
         4'b0100: e.lo = a - b;
         4'b0101: begin e.lo = a - b; s = sa - sb; e.ovf = (s > smax) || (s < smin); end
         4'b0110: e.lo = (ua < ub) ? N'(1) : '0;
         4'b0111: e.lo = (sa < sb) ? N'(1) : '0;
         4'b1000: e.lo = a & b;
         4'b1001: e.lo = a ^ b;
         4'b1010: e.lo = ~(a | b);
         4'b1100: begin p = ua * ub; e.lo = p[N-1:0]; e.hi = p[2*N-1:N]; end
         4'b1101: begin p = 64'(sa * sb); e.lo = p[N-1:0]; e.hi = p[2*N-1:N]; end
         4'b1110: begin
            if (b == '0) begin e.lo = '1; e.hi = a; end
            else begin e.lo = N'(ua / ub); e.hi = N'(ua % ub); end
         end
         4'b1111: begin
            if (b == '0) begin e.lo = '1; e.hi = a; end
            else begin e.lo = N'(sa / sb); e.hi = N'(sa % sb); end
         end
         default: ;
      endcase
      e.zero = (e.lo == '0);
      return e;
   endfunction

   function automatic logic [N-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return N'(1);
         2: return '1;
         3: return {1'b1, {(N-1){1'b0}}};
         4: return {1'b0, {(N-1){1'b1}}};
         5: return N'($urandom_range(0, 15));
         6: return -N'($urandom_range(1, 20));
         default: return N'($urandom);
      endcase
   endfunction

   // Issue one operation at a negedge once the DUT is free; optionally pulse a stray start while busy
   task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input int junk_at);
      exp_t e;
      int   n;
      logic mc;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++; errors++;
         $display("FAIL busy_timeout busy=%b want=0", busy);
      end
`ifdef ALU_FAST_MUL_EN
      mc = (op[3:1] == 3'b111);
`else
      mc = (op[3:2] == 2'b11);
`endif
      e = model(op, a, b);
      e.cyc = cyc + 1 + (mc ? N : 0);
      exp_q.push_back(e);
      start = 1'b1; ALUctr = op; A = a; B = b;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'(mc));
      n = 1;
      if (junk_at > 0) begin
         while (busy && n < 200) begin
            if (n == junk_at) begin
               start = 1'b1; ALUctr = 4'($urandom); A = N'($urandom); B = N'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            n++;
         end
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done Result=%h want=no_done", Result);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result",     64'(Result),   64'(e.lo));
            chk("result_hi",  64'(ResultHi), 64'(e.hi));
            chk("zero",       64'(Zero),     64'(e.zero));
            chk("overflow",   64'(Overflow), 64'(e.ovf));
            chk("done_cycle", 64'(cyc),      64'(e.cyc));
            chk("busy_at_done", 64'(busy),   64'(0));
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; ALUctr = '0; A = '0; B = '0;
      #3;
      chk("rst_busy",     64'(busy),     64'(0));
      chk("rst_done",     64'(done),     64'(0));
      chk("rst_result",   64'(Result),   64'(0));
      chk("rst_resulthi", 64'(ResultHi), 64'(0));
      chk("rst_zero",     64'(Zero),     64'(0));
      chk("rst_overflow", 64'(Overflow), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      issue(OP_ADD,  32'h7FFF_FFFF, 32'h1, 0);
      issue(OP_ADDU, 32'h7FFF_FFFF, 32'h1, 0);
      issue(OP_SLT,  32'hFFFF_FFFF, 32'h1, 0);
      issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 0);
      issue(OP_SUB,  32'h5, 32'h5, 0);
      issue(OP_SUB,  32'h8000_0000, 32'h1, 0);
      issue(OP_MULT, 32'hFFFF_FFFD, 32'h7, 0);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      issue(OP_DIV,  32'hFFFF_FFF9, 32'h2, 0);
      issue(OP_DIVU, 32'h7, 32'h0, 0);
      issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
      issue(OP_DIV,  32'hFFFF_FFF9, 32'h0, 0);
      issue(OP_DIVU, 32'd100, 32'd7, 5);
      issue(OP_ADDU, 32'h1, 32'h1, 0);
      issue(OP_RSV0, 32'h1234, 32'h5678, 0);
      issue(OP_RSV1, 32'h1234, 32'h5678, 0);
      issue(OP_NOR,  32'h0, 32'h0, 0);

      // Reset in the middle of an iterative multiply
      issue(OP_MULTU, N'($urandom), N'($urandom), 0);
      repeat (9) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy",     64'(busy),     64'(0));
      chk("abort_done",     64'(done),     64'(0));
      chk("abort_result",   64'(Result),   64'(0));
      chk("abort_resulthi", 64'(ResultHi), 64'(0));
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(OP_ADDU, 32'd2, 32'd3, 0);

      // Randomized traffic, back-to-back, with occasional stray starts while busy
      for (int i = 0; i < 250; i++) begin
         issue(4'($urandom_range(0, 15)), pick(), pick(),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0);
      end

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
      end
      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
